hls_mc_bridge: RTL and testbench

Multi-channel successor of the single-kernel HLS bus bridge. It sits between the CPU simple bus (cmd/rsp, no rsp back-pressure) and NUM_CH HLS kernels, each exposing ap_fifo command and response streams. It routes each command to a kernel by address decode and allows up to MAX_OUTSTANDING reads in flight across kernels. Read responses return to the bus strictly in issue order.

---
 rtl/hls_mc_bridge_pkg.sv | 20 ++
 rtl/hls_order_fifo.sv | 49 ++++
 rtl/hls_mc_bridge.sv | 198 +++++++++++++++++++
 tb/tb_hls_mc_bridge.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hls_mc_bridge_pkg.sv
// Shared definitions for hls_mc_bridge: command packing layout, pop kinds and
// the error word returned when the watchdog (HLS_MC_BRIDGE_TIMEOUT_EN) fires.
package hls_mc_bridge_pkg;

  localparam int MASK_W = 4;
  localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;

  // Kernel command word, MSB first: {write, mask[3:0], data, address}.
  function automatic int cmd_width(input int data_w, input int addr_w);
    return 1 + MASK_W + data_w + addr_w;
  endfunction

  typedef enum logic [1:0] {
    POP_NONE,
    POP_INVALID,
    POP_SERVE,
    POP_TIMEOUT
  } pop_kind_e;

endpackage

// File: rtl/hls_order_fifo.sv
// Small synchronous FIFO remembering the channel of every outstanding read,
// so responses can be returned in issue order.
module hls_order_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/hls_mc_bridge.sv
// CPU simple-bus to multi-kernel HLS ap_fifo bridge with in-order read returns.
// Optional watchdog and drop counters are built when HLS_MC_BRIDGE_TIMEOUT_EN is defined.
module hls_mc_bridge
  import hls_mc_bridge_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int NUM_CH          = 2,
  parameter int CH_SEL_LSB      = 12,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  io_bus_cmd_valid,
  output logic                                                  io_bus_cmd_ready,
  input  logic [ADDR_WIDTH-1:0]                                 io_bus_cmd_payload_address,
  input  logic [DATA_WIDTH-1:0]                                 io_bus_cmd_payload_data,
  input  logic [3:0]                                            io_bus_cmd_payload_mask,
  input  logic                                                  io_bus_cmd_payload_write,
  output logic                                                  io_bus_rsp_valid,
  output logic [DATA_WIDTH-1:0]                                 io_bus_rsp_payload_data,
  output logic [NUM_CH*cmd_width(DATA_WIDTH, ADDR_WIDTH)-1:0]   hls_cmd_din,
  output logic [NUM_CH-1:0]                                     hls_cmd_write,
  input  logic [NUM_CH-1:0]                                     hls_cmd_full_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0]                          hls_rsp_dout,
  input  logic [NUM_CH-1:0]                                     hls_rsp_empty_n,
  output logic [NUM_CH-1:0]                                     hls_rsp_read,
  output logic                                                  timeout_err
);
  localparam int CH_BITS = $clog2(NUM_CH + 1);
  localparam int CMD_W   = cmd_width(DATA_WIDTH, ADDR_WIDTH);
  localparam int CNT_W   = $clog2(MAX_OUTSTANDING) + 1;
  // A mis-parameterised bridge refuses all traffic instead of misrouting it.
  localparam bit CFG_OK  = (CH_SEL_LSB + CH_BITS <= ADDR_WIDTH) &&
                           (MAX_OUTSTANDING >= 2) && (TIMEOUT_CYCLES >= 1);

  logic [CH_BITS-1:0]    cmd_ch;
  logic [CH_BITS-1:0]    head_ch;
  logic                  cmd_ch_ok;
  logic                  head_ch_ok;
  logic                  sel_full_n;
  logic                  sel_empty_n;
  logic [DATA_WIDTH-1:0] sel_dout;
  logic [CMD_W-1:0]      payload;
  logic [CNT_W-1:0]      order_count;
  logic                  order_full;
  logic                  order_empty;
  logic                  room;
  logic                  accept;
  logic                  push;
  logic                  pop;
  pop_kind_e             pop_kind;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  assign cmd_ch     = io_bus_cmd_payload_address[CH_SEL_LSB +: CH_BITS];
  assign cmd_ch_ok  = (cmd_ch < CH_BITS'(NUM_CH));
  assign head_ch_ok = (head_ch < CH_BITS'(NUM_CH));
  assign payload    = {io_bus_cmd_payload_write, io_bus_cmd_payload_mask,
                       io_bus_cmd_payload_data, io_bus_cmd_payload_address};

  always_comb begin
    sel_full_n  = 1'b0;
    sel_empty_n = 1'b0;
    sel_dout    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cmd_ch == CH_BITS'(i)) sel_full_n = hls_cmd_full_n[i];
      if (head_ch == CH_BITS'(i)) begin
        sel_empty_n = hls_rsp_empty_n[i];
        sel_dout    = hls_rsp_dout[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign room   = !order_full && (order_count < CNT_W'(MAX_OUTSTANDING));
  assign io_bus_cmd_ready = CFG_OK && rst_n && (!cmd_ch_ok || sel_full_n) &&
                            (io_bus_cmd_payload_write || room);
  assign accept = io_bus_cmd_valid && io_bus_cmd_ready;
  assign push   = accept && !io_bus_cmd_payload_write;

  // Every slice shows the payload; only the addressed one carries the write bit.
  always_comb begin
    hls_cmd_din   = '0;
    hls_cmd_write = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst_n)
        hls_cmd_din[i*CMD_W +: CMD_W] =
          {io_bus_cmd_payload_write && (cmd_ch == CH_BITS'(i)), payload[CMD_W-2:0]};
      hls_cmd_write[i] = accept && (cmd_ch == CH_BITS'(i));
    end
  end

  hls_order_fifo #(
    .WIDTH (CH_BITS),
    .DEPTH (MAX_OUTSTANDING)
  ) u_order_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (cmd_ch),
    .pop       (pop),
    .head      (head_ch),
    .count     (order_count),
    .full      (order_full),
    .empty     (order_empty)
  );

`ifdef HLS_MC_BRIDGE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]            drop_cnt [NUM_CH];
  logic [NUM_CH-1:0]     silent_pop;
  logic [WD_W-1:0]       wd_cnt;
  logic                  head_dropping;
  logic                  stalled;
  logic                  timeout_q;
  logic [DATA_WIDTH-1:0] err_word;

  always_comb begin
    head_dropping = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      silent_pop[i] = (drop_cnt[i] != 3'd0) && hls_rsp_empty_n[i];
      if (head_ch == CH_BITS'(i)) head_dropping = (drop_cnt[i] != 3'd0);
    end
    for (int b = 0; b < DATA_WIDTH; b++) err_word[b] = ERR_PATTERN[b % 32];
  end

  assign stalled     = !order_empty && head_ch_ok && !sel_empty_n;
  assign timeout_err = timeout_q;

  // Watchdog restarts on any pop; a timeout leaves one late datum to discard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) drop_cnt[i] <= 3'd0;
    end else begin
      if (pop)          wd_cnt <= '0;
      else if (stalled) wd_cnt <= wd_cnt + WD_W'(1);
      if (pop_kind == POP_TIMEOUT) timeout_q <= 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (pop_kind == POP_TIMEOUT && head_ch == CH_BITS'(i) && drop_cnt[i] != 3'd7)
          drop_cnt[i] <= drop_cnt[i] + 3'd1;
        else if (silent_pop[i])
          drop_cnt[i] <= drop_cnt[i] - 3'd1;
      end
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    pop_kind = POP_NONE;
    if (!order_empty) begin
      if (!head_ch_ok) pop_kind = POP_INVALID;
`ifdef HLS_MC_BRIDGE_TIMEOUT_EN
      else if (sel_empty_n) pop_kind = head_dropping ? POP_NONE : POP_SERVE;
      else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) pop_kind = POP_TIMEOUT;
`else
      else if (sel_empty_n) pop_kind = POP_SERVE;
`endif
    end
  end

  assign pop = (pop_kind != POP_NONE);

  always_comb begin
    hls_rsp_read = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hls_rsp_read[i] = (pop_kind == POP_SERVE) && (head_ch == CH_BITS'(i));
`ifdef HLS_MC_BRIDGE_TIMEOUT_EN
      if (silent_pop[i]) hls_rsp_read[i] = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= pop;
      case (pop_kind)
        POP_SERVE:   rsp_data_q <= sel_dout;
`ifdef HLS_MC_BRIDGE_TIMEOUT_EN
        POP_TIMEOUT: rsp_data_q <= err_word;
`endif
        default:     rsp_data_q <= '0;
      endcase
    end
  end

  assign io_bus_rsp_valid        = rsp_valid_q;
  assign io_bus_rsp_payload_data = rsp_data_q;

endmodule

// File: tb/tb_hls_mc_bridge.sv
// Self-checking bench for hls_mc_bridge: vector table, hand-written order/backpressure/
// reset sequences, and randomized traffic against a queue-based reference model.
module tb_hls_mc_bridge;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int NCH  = 2;
  localparam int CMDW = 1 + 4 + DW + AW;
  localparam int MAXO = 4;
  localparam int TO   = 16;
`ifdef HLS_MC_BRIDGE_TIMEOUT_EN
  localparam bit TO_BUILD = 1'b1;
`else
  localparam bit TO_BUILD = 1'b0;
`endif

  logic                 clk;
  logic                 rst_n;
  logic                 io_bus_cmd_valid;
  logic                 io_bus_cmd_ready;
  logic [AW-1:0]        io_bus_cmd_payload_address;
  logic [DW-1:0]        io_bus_cmd_payload_data;
  logic [3:0]           io_bus_cmd_payload_mask;
  logic                 io_bus_cmd_payload_write;
  logic                 io_bus_rsp_valid;
  logic [DW-1:0]        io_bus_rsp_payload_data;
  logic [NCH*CMDW-1:0]  hls_cmd_din;
  logic [NCH-1:0]       hls_cmd_write;
  logic [NCH-1:0]       hls_cmd_full_n;
  logic [NCH*DW-1:0]    hls_rsp_dout;
  logic [NCH-1:0]       hls_rsp_empty_n;
  logic [NCH-1:0]       hls_rsp_read;
  logic                 timeout_err;

  hls_mc_bridge #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH), .CH_SEL_LSB(12),
    .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .io_bus_cmd_valid(io_bus_cmd_valid), .io_bus_cmd_ready(io_bus_cmd_ready),
    .io_bus_cmd_payload_address(io_bus_cmd_payload_address),
    .io_bus_cmd_payload_data(io_bus_cmd_payload_data),
    .io_bus_cmd_payload_mask(io_bus_cmd_payload_mask),
    .io_bus_cmd_payload_write(io_bus_cmd_payload_write),
    .io_bus_rsp_valid(io_bus_rsp_valid), .io_bus_rsp_payload_data(io_bus_rsp_payload_data),
    .hls_cmd_din(hls_cmd_din), .hls_cmd_write(hls_cmd_write), .hls_cmd_full_n(hls_cmd_full_n),
    .hls_rsp_dout(hls_rsp_dout), .hls_rsp_empty_n(hls_rsp_empty_n), .hls_rsp_read(hls_rsp_read),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] data;
  } ord_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [1:0]  full_n;
    logic        exp_ready;
    logic [1:0]  exp_wr;
    logic        exp_rsp;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] kq  [NCH][$];
  logic [31:0] src [NCH][$];
  ord_t        order_q [$];
  logic        m_rv;
  logic [31:0] m_rdata;

  logic                s_ready, s_rv, s_terr;
  logic [NCH-1:0]      s_cwr, s_rd;
  logic [NCH*CMDW-1:0] s_din;
  logic [DW-1:0]       s_rdata;

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] m);
    io_bus_cmd_valid           = v;
    io_bus_cmd_payload_write   = w;
    io_bus_cmd_payload_address = a;
    io_bus_cmd_payload_data    = d;
    io_bus_cmd_payload_mask    = m;
  endtask

  task automatic drive_kernels();
    for (int i = 0; i < NCH; i++) begin
      hls_rsp_empty_n[i]         = (kq[i].size() > 0);
      hls_rsp_dout[i*DW +: DW]   = (kq[i].size() > 0) ? kq[i][0] : 32'h0;
    end
  endtask

  // Snapshot the cycle's outputs at the falling edge, then let the kernels react.
  task automatic tick();
    @(negedge clk);
    s_ready = io_bus_cmd_ready;  s_cwr = hls_cmd_write; s_din = hls_cmd_din;
    s_rd    = hls_rsp_read;      s_rv  = io_bus_rsp_valid;
    s_rdata = io_bus_rsp_payload_data; s_terr = timeout_err;
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++)
      if (s_rd[i] && kq[i].size() > 0) void'(kq[i].pop_front());
    drive_kernels();
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    hls_cmd_full_n = '1;
    for (int i = 0; i < NCH; i++) begin
      kq[i].delete();
      src[i].delete();
    end
    order_q.delete();
    m_rv = 1'b0;
    m_rdata = 32'h0;
    drive_kernels();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One randomized cycle; expectations come from the queue model, never the DUT.
  task automatic randomCycle(input bit allow_cmd);
    logic v, w, pop;
    logic [1:0] ch, full_n, exp_rd, exp_wr;
    logic exp_ready;
    logic [31:0] addr, d, pdata;
    for (int i = 0; i < NCH; i++)
      if (src[i].size() > 0 && (TO_BUILD || $urandom_range(0, 3) != 0))
        kq[i].push_back(src[i].pop_front());
    drive_kernels();
    v      = allow_cmd && ($urandom_range(0, 2) != 0);
    w      = $urandom_range(0, 2) == 0;
    ch     = 2'($urandom_range(0, 3));
    addr   = {18'h0, ch, 12'($urandom)};
    full_n = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
    applyStimulus(v, w, addr, $urandom, 4'($urandom));
    hls_cmd_full_n = full_n;
    exp_ready = (ch >= 2 || full_n[ch[0]]) && (w || order_q.size() < MAXO);
    exp_wr = (v && exp_ready && ch < 2) ? (2'b01 << ch) : 2'b00;
    pop = 1'b0; exp_rd = 2'b00; pdata = 32'h0;
    if (order_q.size() > 0) begin
      if (order_q[0].ch >= 2) pop = 1'b1;
      else if (kq[order_q[0].ch[0]].size() > 0) begin
        pop = 1'b1;
        exp_rd = 2'b01 << order_q[0].ch;
      end
      if (pop) pdata = order_q[0].data;
    end
    tick();
    checkOutput("rnd_ready", s_ready, exp_ready);
    checkOutput("rnd_cmd_write", s_cwr, exp_wr);
    checkOutput("rnd_rsp_read", s_rd, exp_rd);
    checkOutput("rnd_rsp_valid", s_rv, m_rv);
    if (m_rv) checkOutput("rnd_rsp_data", s_rdata, m_rdata);
    m_rv = pop;
    m_rdata = pdata;
    if (pop) void'(order_q.pop_front());
    if (v && exp_ready && !w) begin
      d = (ch < 2) ? $urandom : 32'h0;
      order_q.push_back('{ch, d});
      if (ch < 2) src[ch[0]].push_back(d);
    end
  endtask

  vec_t vecs [8];

  initial begin
    logic [NCH*CMDW-1:0] exp_din;
    logic [1:0] vch;
    int found;
    bit seen;

    vecs[0] = '{1'b1, 32'h0000_1004, 32'hA5A5_0001, 4'hF, 2'b11, 1'b1, 2'b10, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0008, 32'h1234_5678, 4'h3, 2'b11, 1'b1, 2'b01, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0008, 32'h1234_5678, 4'h3, 2'b10, 1'b0, 2'b00, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_3000, 32'hCAFE_0003, 4'h1, 2'b00, 1'b1, 2'b00, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_3000, 32'h0000_0000, 4'hF, 2'b00, 1'b1, 2'b00, 1'b1};
    vecs[5] = '{1'b0, 32'h0000_2010, 32'h0000_0000, 4'hF, 2'b11, 1'b1, 2'b00, 1'b1};
    vecs[6] = '{1'b1, 32'h0000_1FFC, 32'h0BAD_0006, 4'hC, 2'b01, 1'b0, 2'b00, 1'b0};
    vecs[7] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'hF, 2'b10, 1'b0, 2'b00, 1'b0};

    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
    hls_cmd_full_n = '1;
    drive_kernels();
    #2;
    checkOutput("reset_ready", io_bus_cmd_ready, 1'b0);
    checkOutput("reset_cmd_write", hls_cmd_write, 2'b00);
    checkOutput("reset_cmd_din", hls_cmd_din, '0);
    checkOutput("reset_rsp_valid", io_bus_rsp_valid, 1'b0);
    checkOutput("reset_rsp_data", io_bus_rsp_payload_data, 32'h0);
    checkOutput("reset_rsp_read", hls_rsp_read, 2'b00);
    checkOutput("reset_timeout_err", timeout_err, 1'b0);
    resetDut();

    $display("[TB] vector table");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, vecs[k].wr, vecs[k].addr, vecs[k].data, vecs[k].mask);
      hls_cmd_full_n = vecs[k].full_n;
      vch = vecs[k].addr[13:12];
      for (int i = 0; i < NCH; i++)
        exp_din[i*CMDW +: CMDW] = {(vch == 2'(i)) ? vecs[k].wr : 1'b0,
                                   vecs[k].mask, vecs[k].data, vecs[k].addr};
      tick();
      checkOutput($sformatf("vec%0d_ready", k), s_ready, vecs[k].exp_ready);
      checkOutput($sformatf("vec%0d_cmd_write", k), s_cwr, vecs[k].exp_wr);
      checkOutput($sformatf("vec%0d_din", k), s_din, exp_din);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      hls_cmd_full_n = '1;
      tick();
      tick();
      checkOutput($sformatf("vec%0d_rsp_valid", k), s_rv, vecs[k].exp_rsp);
      if (vecs[k].exp_rsp) checkOutput($sformatf("vec%0d_rsp_data", k), s_rdata, 32'h0);
    end

    $display("[TB] in-order return across channels");
    resetDut();
    applyStimulus(1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'hF);
    tick();
    checkOutput("ord_acc0", s_ready, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
    tick();
    checkOutput("ord_acc1", s_ready, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    kq[1].push_back(32'h22);
    drive_kernels();
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("ord_wait_read", s_rd, 2'b00);
      checkOutput("ord_wait_valid", s_rv, 1'b0);
    end
    kq[0].push_back(32'h11);
    drive_kernels();
    tick();
    checkOutput("ord_pop0", s_rd, 2'b01);
    tick();
    checkOutput("ord_rsp0_valid", s_rv, 1'b1);
    checkOutput("ord_rsp0_data", s_rdata, 32'h11);
    checkOutput("ord_pop1", s_rd, 2'b10);
    tick();
    checkOutput("ord_rsp1_valid", s_rv, 1'b1);
    checkOutput("ord_rsp1_data", s_rdata, 32'h22);
    tick();
    checkOutput("ord_idle", s_rv, 1'b0);

    $display("[TB] outstanding limit");
    resetDut();
    applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput($sformatf("lim_ready%0d", k), s_ready, (k < MAXO) ? 1'b1 : 1'b0);
    end
    for (int k = 0; k < 4; k++) kq[0].push_back(32'hB0 + 32'(k));
    drive_kernels();
    tick();
    checkOutput("lim_first_pop", s_rd, 2'b01);
    checkOutput("lim_no_bypass", s_ready, 1'b0);
    tick();
    checkOutput("lim_fifth_acc", s_ready, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("lim_rsp0", {s_rv, s_rdata}, {1'b1, 32'hB0});
    for (int k = 1; k < 4; k++) begin
      tick();
      checkOutput($sformatf("lim_rsp%0d", k), {s_rv, s_rdata}, {1'b1, 32'hB0 + 32'(k)});
    end
    tick();
    checkOutput("lim_gap", s_rv, 1'b0);
    kq[0].push_back(32'hB4);
    drive_kernels();
    tick();
    tick();
    checkOutput("lim_rsp4", {s_rv, s_rdata}, {1'b1, 32'hB4});

    $display("[TB] reset with reads outstanding");
    resetDut();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    #2 rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h0000_1000, 32'h5555_AAAA, 4'hF);
    #1;
    checkOutput("mid_rst_ready", io_bus_cmd_ready, 1'b0);
    checkOutput("mid_rst_cmd_write", hls_cmd_write, 2'b00);
    checkOutput("mid_rst_din", hls_cmd_din, '0);
    checkOutput("mid_rst_rsp", {io_bus_rsp_valid, io_bus_rsp_payload_data}, 33'h0);
    checkOutput("mid_rst_read", hls_rsp_read, 2'b00);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'hF);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    kq[0].push_back(32'h77);
    drive_kernels();
    tick();
    checkOutput("post_rst_pop", s_rd, 2'b01);
    tick();
    checkOutput("post_rst_rsp", {s_rv, s_rdata}, {1'b1, 32'h77});
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (s_rv) seen = 1'b1;
    end
    checkOutput("post_rst_no_stale", seen, 1'b0);

`ifdef HLS_MC_BRIDGE_TIMEOUT_EN
    $display("[TB] watchdog");
    resetDut();
    applyStimulus(1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'hF);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    found = -1;
    for (int t = 1; t <= 40 && found < 0; t++) begin
      tick();
      if (s_rv) begin
        found = t;
        checkOutput("to_data", s_rdata, 32'hDEAD_BEEF);
        checkOutput("to_err_set", s_terr, 1'b1);
      end
    end
    checkOutput("to_cycle", 32'(found), 32'd17);
    kq[0].push_back(32'h55);
    drive_kernels();
    tick();
    checkOutput("to_silent_pop", {s_rd, s_rv}, {2'b01, 1'b0});
    tick();
    checkOutput("to_after_silent", {s_rd, s_rv}, {2'b00, 1'b0});
    applyStimulus(1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'hF);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    kq[0].push_back(32'h66);
    drive_kernels();
    tick();
    tick();
    checkOutput("to_fresh", {s_rv, s_rdata}, {1'b1, 32'h66});
    checkOutput("to_err_sticky", s_terr, 1'b1);
`endif

    $display("[TB] randomized traffic");
    resetDut();
    for (int c = 0; c < 400; c++) randomCycle(1'b1);
    for (int c = 0; c < 60 && (order_q.size() > 0 || m_rv); c++) randomCycle(1'b0);
    checkOutput("rnd_drained", 32'(order_q.size()), 32'd0);
    if (!TO_BUILD) checkOutput("no_timeout_err", s_terr, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
